bcd_convert_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 4-bit-to-two-digit-decimal converter among NCH requesters.
- Each requester presents a 4-bit binary value (0..15) with a level request.
- The block grants one requester at a time, drives the shared converter, and latches the result into that channel's tens/ones 7-segment registers.
- Sits between switch/counter sources and the HEX display pins on the DE1-SoC top level.

---
 rtl/bcd_pkg.sv | 43 ++++
 rtl/dec_digits.sv | 24 ++
 rtl/bcd_convert_arbiter.sv | 120 ++++++++++++
 tb/tb_bcd_convert_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD converter arbiter.
package bcd_pkg;

    // Default number of requesting channels.
    localparam int unsigned NCH_DFLT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        ACK     = 2'd2
    } state_t;

    // Active-low 7-segment codes, bit6=g ... bit0=a.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Decimal digit to segment pattern; anything above 9 blanks the digit.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/dec_digits.sv
// Combinational 4-bit binary to two-digit decimal 7-segment converter.
module dec_digits
    import bcd_pkg::*;
(
    input  logic [3:0] v,
    output logic [6:0] tens_seg,
    output logic [6:0] ones_seg
);

    logic [3:0] w_ones;

    // Split 0..15 into tens (0 or 1) and ones (0..9), then encode both digits.
    always_comb begin
        if (v >= 4'd10) begin
            tens_seg = SEG_1;
            w_ones   = v - 4'd10;
        end else begin
            tens_seg = SEG_0;
            w_ones   = v;
        end
        ones_seg = seg_of(w_ones);
    end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter sharing one decimal converter among NCH requesters,
// with a per-channel tens/ones segment register file.
module bcd_convert_arbiter
    import bcd_pkg::*;
#(
    parameter int unsigned NCH = NCH_DFLT,
    parameter int unsigned IW  = $clog2(NCH)
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic [NCH-1:0]     req,
    input  logic [4*NCH-1:0]   val,
    output logic [NCH-1:0]     ack,
    output logic               busy,
    output logic [7*NCH-1:0]   seg_tens,
    output logic [7*NCH-1:0]   seg_ones
);

    state_t             r_state;
    state_t             w_state_next;
    logic [IW-1:0]      r_rr;
    logic [IW-1:0]      r_gnt;
    logic [3:0]         r_op;
    logic [NCH-1:0]     r_ack;
    logic               r_busy;
    logic [7*NCH-1:0]   r_seg_tens;
    logic [7*NCH-1:0]   r_seg_ones;

    logic [IW-1:0]      w_pick;
    logic [IW-1:0]      w_idx;
    logic               w_found;
    logic [3:0]         w_val [NCH];
    logic [NCH-1:0]     w_gnt_onehot;
    logic [6:0]         w_tens;
    logic [6:0]         w_ones;

    // Unpack channel values and decode the current grant to one-hot.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            w_val[i]        = val[4*i +: 4];
            w_gnt_onehot[i] = (r_gnt == IW'(i));
        end
    end

    // Round-robin search: first set req bit starting just after the last grant.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            w_idx = IW'((32'(r_rr) + i) % NCH);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // The single shared converter always works on the latched operand.
    dec_digits u_dec_digits (
        .v        (r_op),
        .tens_seg (w_tens),
        .ones_seg (w_ones)
    );

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> CONVERT -> ACK -> IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_next = CONVERT;
            CONVERT: w_state_next = ACK;
            ACK:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Grant latch, segment register file and registered handshake outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_rr       <= IW'(NCH - 1);
            r_gnt      <= '0;
            r_op       <= '0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_seg_tens <= {NCH{SEG_BLANK}};
            r_seg_ones <= {NCH{SEG_BLANK}};
        end else begin
            if (r_state == IDLE && w_found) begin
                r_gnt <= w_pick;
                r_rr  <= w_pick;
                r_op  <= w_val[w_pick];
            end
            if (r_state == CONVERT) begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (r_gnt == IW'(i)) begin
                        r_seg_tens[7*i +: 7] <= w_tens;
                        r_seg_ones[7*i +: 7] <= w_ones;
                    end
                end
            end
            r_busy <= (w_state_next != IDLE);
            r_ack  <= (w_state_next == ACK) ? w_gnt_onehot : '0;
        end
    end

    assign ack      = r_ack;
    assign busy     = r_busy;
    assign seg_tens = r_seg_tens;
    assign seg_ones = r_seg_ones;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Self-checking bench: behavioural model compared every cycle plus literal pins.
module tb_bcd_convert_arbiter;

    localparam int NCH = 4;

    logic           Clock  = 1'b0;
    logic           Resetn = 1'b0;
    logic [3:0]     req    = '0;
    logic [15:0]    val    = '0;
    logic [3:0]     ack;
    logic           busy;
    logic [27:0]    seg_tens;
    logic [27:0]    seg_ones;

    bcd_convert_arbiter #(.NCH(NCH)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .req      (req),
        .val      (val),
        .ack      (ack),
        .busy     (busy),
        .seg_tens (seg_tens),
        .seg_ones (seg_ones)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // Segment patterns for decimal digits.
    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Behavioural model: a job is granted at edge c0, shows results at c0+1, ends at c0+2.
    logic [6:0] m_tens [NCH];
    logic [6:0] m_ones [NCH];
    int         m_rr, m_ch, m_c0, m_cyc, m_v;
    bit         m_active;
    logic [3:0] m_ack;
    logic       m_busy;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_tens[i] = 7'h7f;
            m_ones[i] = 7'h7f;
        end
        m_rr = NCH - 1; m_ch = 0; m_c0 = 0; m_cyc = 0; m_v = 0;
        m_active = 1'b0; m_ack = '0; m_busy = 1'b0;
    endtask

    task automatic model_step();
        m_cyc++;
        if (m_active && m_cyc == m_c0 + 1) begin
            m_tens[m_ch] = digit_seg(m_v / 10);
            m_ones[m_ch] = digit_seg(m_v % 10);
            m_ack = '0;
            m_ack[m_ch] = 1'b1;
        end else if (m_active && m_cyc == m_c0 + 2) begin
            m_active = 1'b0;
            m_ack = '0;
        end else if (!m_active && req != 0) begin
            for (int i = 1; i <= NCH; i++) begin
                if (req[(m_rr + i) % NCH]) begin
                    m_ch = (m_rr + i) % NCH;
                    break;
                end
            end
            m_rr = m_ch;
            m_v = int'(val[4*m_ch +: 4]);
            m_c0 = m_cyc;
            m_active = 1'b1;
        end
        m_busy = m_active;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clock or negedge Resetn);
            if (!Resetn) model_reset();
            else model_step();
        end
    end

    // Compare every cycle on the falling edge.
    initial begin
        logic [27:0] et, eo;
        forever begin
            @(negedge Clock);
            for (int i = 0; i < NCH; i++) begin
                et[7*i +: 7] = m_tens[i];
                eo[7*i +: 7] = m_ones[i];
            end
            chk("cmp_busy", 32'(busy), 32'(m_busy));
            chk("cmp_ack", 32'(ack), 32'(m_ack));
            chk("cmp_seg_tens", 32'(seg_tens), 32'(et));
            chk("cmp_seg_ones", 32'(seg_ones), 32'(eo));
        end
    end

    // One isolated conversion with literal expectations.
    task automatic single(input int ch, input logic [3:0] v, input logic [6:0] et,
                          input logic [6:0] eo);
        logic [3:0] ea;
        ea = '0;
        ea[ch] = 1'b1;
        @(negedge Clock);
        val[4*ch +: 4] = v;
        req = ea;
        @(negedge Clock);
        chk("single_busy_conv", 32'(busy), 32'd1);
        chk("single_ack_conv", 32'(ack), 32'd0);
        @(negedge Clock);
        chk("single_busy_ack", 32'(busy), 32'd1);
        chk("single_ack", 32'(ack), 32'(ea));
        chk("single_tens", 32'(seg_tens[7*ch +: 7]), 32'(et));
        chk("single_ones", 32'(seg_ones[7*ch +: 7]), 32'(eo));
        req = '0;
        @(negedge Clock);
        chk("single_idle", 32'(busy), 32'd0);
    endtask

    int ord [8];
    int at  [8];
    int n_ack;

    // Record ack order/timing over a bounded window; channels in hold keep req up.
    task automatic collect(input int cycles, input logic [3:0] hold);
        n_ack = 0;
        for (int j = 1; j <= cycles; j++) begin
            @(negedge Clock);
            if (ack != 0 && n_ack < 8) begin
                for (int i = 0; i < NCH; i++) if (ack[i]) ord[n_ack] = i;
                at[n_ack] = j;
                n_ack++;
                req = req & ~(ack & ~hold);
            end
        end
    endtask

    initial begin
        // Reset and release.
        repeat (2) @(negedge Clock);
        chk("rst_tens", 32'(seg_tens), 32'h0fff_ffff);
        chk("rst_busy", 32'(busy), 32'd0);
        Resetn = 1'b1;

        // Single channel: ch2 = 13.
        single(2, 4'd13, 7'b1111001, 7'b0110000);
        chk("single_others_tens", 32'(seg_tens), 32'({7'h7f, 7'b1111001, 7'h7f, 7'h7f}));
        chk("single_others_ones", 32'(seg_ones), 32'({7'h7f, 7'b0110000, 7'h7f, 7'h7f}));

        // Asynchronous reset mid-cycle.
        @(posedge Clock);
        #3;
        Resetn = 1'b0;
        #1;
        chk("async_rst_tens", 32'(seg_tens), 32'h0fff_ffff);
        chk("async_rst_ones", 32'(seg_ones), 32'h0fff_ffff);
        chk("async_rst_ack", 32'(ack), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;

        // 9 / 10 / 15 boundary on ch0.
        single(0, 4'd9,  7'b1000000, 7'b0010000);
        single(0, 4'd10, 7'b1111001, 7'b1000000);
        single(0, 4'd15, 7'b1111001, 7'b0010010);

        // Round-robin with all four requesting from reset.
        @(negedge Clock);
        Resetn = 1'b0;
        val = {4'd6, 4'd5, 4'd4, 4'd3};
        req = 4'hf;
        @(negedge Clock);
        Resetn = 1'b1;
        collect(14, 4'h0);
        chk("rr_count", 32'(n_ack), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", 32'(ord[i]), 32'(i));
            chk("rr_time", 32'(at[i]), 32'(2 + 3 * i));
        end

        // req=1001 after ch3 was last: wraps to ch0 first.
        req = 4'b1001;
        collect(8, 4'h0);
        chk("wrap_count", 32'(n_ack), 32'd2);
        chk("wrap_first", 32'(ord[0]), 32'd0);
        chk("wrap_second", 32'(ord[1]), 32'd3);

        // ch1 holds req; ch2 must be serviced between ch1 grants.
        req = 4'b0110;
        collect(9, 4'b0010);
        req = '0;
        chk("hold_count", 32'(n_ack), 32'd3);
        chk("hold_first", 32'(ord[0]), 32'd1);
        chk("hold_second", 32'(ord[1]), 32'd2);
        chk("hold_third", 32'(ord[2]), 32'd1);

        // Reset during CONVERT abandons the job.
        @(negedge Clock);
        val[15:12] = 4'd7;
        req = 4'b1000;
        @(posedge Clock);
        #2;
        chk("mc_busy_pre", 32'(busy), 32'd1);
        Resetn = 1'b0;
        #1;
        req = '0;
        chk("mc_busy", 32'(busy), 32'd0);
        chk("mc_ones3", 32'(seg_ones[27:21]), 32'h7f);
        for (int j = 0; j < 3; j++) begin
            @(negedge Clock);
            chk("mc_no_ack", 32'(ack), 32'd0);
        end
        Resetn = 1'b1;
        single(3, 4'd7, 7'b1000000, 7'b1111000);

        repeat (2) @(negedge Clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
